// File: rtl/window_3x3_line_buffer.sv
// 3x3 neighbourhood generator for a raster-order 8-bit grey pixel stream.
// Two line buffers hold the previous two rows. A 3x3 register window shifts
// left on every accepted pixel. oWindowValid pulses for one cycle whenever
// the window is centred on an interior pixel.
module window_3x3_line_buffer #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int COL_W      = 9,
  parameter int ROW_W      = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iSof,
  input  logic             iPixelValid,
  input  logic [7:0]       iv8Pixel,
  output logic [7:0]       ov8Pixel_a,
  output logic [7:0]       ov8Pixel_b,
  output logic [7:0]       ov8Pixel_c,
  output logic [7:0]       ov8Pixel_d,
  output logic [7:0]       ov8Pixel_fij,
  output logic [7:0]       ov8Pixel_e,
  output logic [7:0]       ov8Pixel_f,
  output logic [7:0]       ov8Pixel_g,
  output logic [7:0]       ov8Pixel_h,
  output logic             oWindowValid,
  output logic [COL_W-1:0] ovCenterCol,
  output logic [ROW_W-1:0] ovCenterRow,
  output logic             oFrameDone
);

  // Line buffer address width; the column counter is at least this wide.
  localparam int LB_AW = $clog2(IMG_WIDTH);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  // Position counters: coordinates of the next pixel to be accepted.
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  // Coordinates of the pixel on the input this cycle (iSof forces origin).
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col_next;
  logic [ROW_W-1:0] w_row_next;
  logic             w_accept;
  logic             w_interior;
  logic             w_last_pixel;

  // Line buffers: r_lb0 holds row r-1, r_lb1 holds row r-2.
  logic [7:0]       r_lb0 [0:IMG_WIDTH-1];
  logic [7:0]       r_lb1 [0:IMG_WIDTH-1];
  logic [LB_AW-1:0] w_lb_addr;
  logic [7:0]       w_lb0_rd;
  logic [7:0]       w_lb1_rd;

  // New right-hand window column, indexed top (0) to bottom (2).
  logic [2:0][7:0]  w_new_col;

  // Window register columns exported from the generate block, by row.
  logic [2:0][7:0]  w_win_l;
  logic [2:0][7:0]  w_win_m;
  logic [2:0][7:0]  w_win_r;

  // Registered status outputs.
  logic             r_valid;
  logic             r_done;
  logic [COL_W-1:0] r_center_col;
  logic [ROW_W-1:0] r_center_row;

  assign w_accept     = iPixelValid;
  assign w_col        = iSof ? '0 : r_col;
  assign w_row        = iSof ? '0 : r_row;
  assign w_lb_addr    = w_col[LB_AW-1:0];
  assign w_interior   = (w_row >= ROW_TWO) && (w_col >= COL_TWO);
  assign w_last_pixel = (w_row == LAST_ROW) && (w_col == LAST_COL);

  // Raster advance: column wraps into the next row, last pixel wraps the frame.
  always_comb begin
    w_col_next = w_col + COL_ONE;
    w_row_next = w_row;
    if (w_col == LAST_COL) begin
      w_col_next = '0;
      if (w_row == LAST_ROW) begin
        w_row_next = '0;
      end else begin
        w_row_next = w_row + ROW_ONE;
      end
    end
  end

  // Position counter register; holds while no pixel is offered.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      r_col <= w_col_next;
      r_row <= w_row_next;
    end
  end

  // Old contents are read in the same cycle they are replaced, so the window
  // sees rows r-2 and r-1 for this column alongside the incoming pixel.
  assign w_lb0_rd = r_lb0[w_lb_addr];
  assign w_lb1_rd = r_lb1[w_lb_addr];

  // Line buffer update: age row r-1 into the r-2 buffer, store the new pixel.
  always_ff @(posedge iClk) begin
    if (w_accept) begin
      r_lb1[w_lb_addr] <= w_lb0_rd;
      r_lb0[w_lb_addr] <= iv8Pixel;
    end
  end

  assign w_new_col[0] = w_lb1_rd;
  assign w_new_col[1] = w_lb0_rd;
  assign w_new_col[2] = iv8Pixel;

  // One shift register per window row: left <- middle <- right <- new column.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gen_win_row
      logic [7:0] r_left;
      logic [7:0] r_mid;
      logic [7:0] r_right;

      // Shift this window row left on every accepted pixel.
      always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
          r_left  <= '0;
          r_mid   <= '0;
          r_right <= '0;
        end else if (w_accept) begin
          r_left  <= r_mid;
          r_mid   <= r_right;
          r_right <= w_new_col[gi];
        end
      end

      assign w_win_l[gi] = r_left;
      assign w_win_m[gi] = r_mid;
      assign w_win_r[gi] = r_right;
    end
  endgenerate

  // Valid and frame-done strobes last exactly one cycle after their pixel.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_accept && w_interior;
      r_done  <= w_accept && w_last_pixel;
    end
  end

  // Centre coordinates move together with the window they describe.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_center_col <= '0;
      r_center_row <= '0;
    end else if (w_accept && w_interior) begin
      r_center_col <= w_col - COL_ONE;
      r_center_row <= w_row - ROW_ONE;
    end
  end

  assign ov8Pixel_a   = w_win_l[0];
  assign ov8Pixel_b   = w_win_m[0];
  assign ov8Pixel_c   = w_win_r[0];
  assign ov8Pixel_d   = w_win_l[1];
  assign ov8Pixel_fij = w_win_m[1];
  assign ov8Pixel_e   = w_win_r[1];
  assign ov8Pixel_f   = w_win_l[2];
  assign ov8Pixel_g   = w_win_m[2];
  assign ov8Pixel_h   = w_win_r[2];
  assign oWindowValid = r_valid;
  assign oFrameDone   = r_done;
  assign ovCenterCol  = r_center_col;
  assign ovCenterRow  = r_center_row;

endmodule

// File: tb/tb_window_3x3_line_buffer.sv
// Bench for window_3x3_line_buffer on a 5x4 image: an image-array model
// checked every cycle, plus literal checks on the logged windows.
module tb_window_3x3_line_buffer;
  localparam int W     = 5;
  localparam int H     = 4;
  localparam int COL_W = 3;
  localparam int ROW_W = 2;

  logic             iClk = 1'b0;
  logic             iRst = 1'b1;
  logic             iSof = 1'b0;
  logic             iPixelValid = 1'b0;
  logic [7:0]       iv8Pixel = 8'h00;
  logic [7:0]       a, b, c, d, fij, e, f, g, h;
  logic             oWindowValid;
  logic [COL_W-1:0] ovCenterCol;
  logic [ROW_W-1:0] ovCenterRow;
  logic             oFrameDone;

  window_3x3_line_buffer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(COL_W), .ROW_W(ROW_W)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iSof(iSof), .iPixelValid(iPixelValid),
    .iv8Pixel(iv8Pixel),
    .ov8Pixel_a(a), .ov8Pixel_b(b), .ov8Pixel_c(c),
    .ov8Pixel_d(d), .ov8Pixel_fij(fij), .ov8Pixel_e(e),
    .ov8Pixel_f(f), .ov8Pixel_g(g), .ov8Pixel_h(h),
    .oWindowValid(oWindowValid), .ovCenterCol(ovCenterCol),
    .ovCenterRow(ovCenterRow), .oFrameDone(oFrameDone)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: store accepted pixels in an image array at their raster position.
  logic [7:0]       img [0:H-1][0:W-1];
  int               m_row = 0, m_col = 0, pr = 0, pc = 0;
  logic             exp_valid = 1'b0;
  logic             exp_done  = 1'b0;
  logic [71:0]      exp_win   = '0;
  logic [ROW_W-1:0] exp_crow  = '0;
  logic [COL_W-1:0] exp_ccol  = '0;

  always @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      m_row = 0; m_col = 0;
      exp_valid = 1'b0; exp_done = 1'b0;
    end else if (iPixelValid) begin
      pr = iSof ? 0 : m_row;
      pc = iSof ? 0 : m_col;
      img[pr][pc] = iv8Pixel;
      exp_valid = (pr >= 2) && (pc >= 2);
      exp_done  = (pr == H-1) && (pc == W-1);
      if (exp_valid) begin
        exp_win = {img[pr-2][pc-2], img[pr-2][pc-1], img[pr-2][pc],
                   img[pr-1][pc-2], img[pr-1][pc-1], img[pr-1][pc],
                   img[pr][pc-2],   img[pr][pc-1],   img[pr][pc]};
        exp_crow = ROW_W'(pr - 1);
        exp_ccol = COL_W'(pc - 1);
      end
      m_col = pc + 1;
      m_row = pr;
      if (m_col == W) begin
        m_col = 0;
        m_row = (pr == H-1) ? 0 : pr + 1;
      end
    end else begin
      exp_valid = 1'b0;
      exp_done  = 1'b0;
    end
  end

  typedef struct packed {
    logic [71:0]      win;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             done;
  } win_t;
  win_t win_log[$];

  wire [71:0] dut_win = {a, b, c, d, fij, e, f, g, h};

  // Compare process on the falling edge, away from the active edge.
  always @(negedge iClk) begin
    if (iRst) begin
      chk("reset_outputs", {dut_win, oWindowValid, ovCenterCol, ovCenterRow, oFrameDone}, '0);
    end else begin
      chk("window_valid", oWindowValid, exp_valid);
      chk("frame_done", oFrameDone, exp_done);
      if (exp_valid) begin
        chk("window_pixels", dut_win, exp_win);
        chk("centre_rc", {ovCenterRow, ovCenterCol}, {exp_crow, exp_ccol});
      end
      if (oWindowValid) begin
        win_log.push_back('{win: dut_win, row: ovCenterRow, col: ovCenterCol, done: oFrameDone});
        $display("window row=%0d col=%0d a=%0d fij=%0d h=%0d done=%0b",
                 ovCenterRow, ovCenterCol, a, fij, h, oFrameDone);
      end
    end
  end

  // Drive one cycle of inputs, then advance past the next rising edge.
  task automatic pixel(input logic sof, input logic vld, input logic [7:0] pix);
    iSof = sof; iPixelValid = vld; iv8Pixel = pix;
    @(posedge iClk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pixel(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int base, input logic sof, input logic gaps);
    for (int r = 0; r < H; r++)
      for (int cc = 0; cc < W; cc++) begin
        pixel(sof && r == 0 && cc == 0, 1'b1, 8'(base + 16*r + cc));
        if (gaps) pixel(1'b1, 1'b0, 8'hEE);
      end
  endtask

  // Hand-derived expectations: 6 windows per frame, centres (1,1)..(2,3).
  task automatic check_frames(input string tag, input int nframes, input int base0, input int base1);
    logic [71:0] w;
    int base, cr, cc, idx;
    chk({tag, "_count"}, win_log.size(), 6*nframes);
    if (win_log.size() != 6*nframes) return;
    for (int fr = 0; fr < nframes; fr++) begin
      base = (fr == 0) ? base0 : base1;
      for (int k = 0; k < 6; k++) begin
        idx = fr*6 + k;
        cr = 1 + k/3; cc = 1 + k%3;
        w = '0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            w = {w[63:0], 8'(base + 16*(cr+dr) + cc + dc)};
        chk({tag, "_win"}, win_log[idx].win, w);
        chk({tag, "_centre"}, {win_log[idx].row, win_log[idx].col}, {ROW_W'(cr), COL_W'(cc)});
        chk({tag, "_done"}, win_log[idx].done, k == 5);
      end
    end
  endtask

  initial begin
    logic [71:0] first;
    idle(3);
    iRst = 1'b0;
    idle(2);

    // Scenario 1: continuous frame with iSof.
    win_log.delete();
    send_frame(0, 1'b1, 1'b0);
    idle(3);
    check_frames("s1", 1, 0, 0);
    if (win_log.size() == 6) begin
      chk("s1_first_window", win_log[0].win, {8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34});
      chk("s1_last_fij", win_log[5].win[39:32], 8'd35);
      chk("s1_last_h", win_log[5].win[7:0], 8'd52);
    end

    // Scenario 2: valid toggled every cycle (idle cycles carry a stray iSof).
    win_log.delete();
    send_frame(0, 1'b1, 1'b1);
    idle(3);
    check_frames("s2", 1, 0, 0);

    // Scenario 3: back-to-back frames, second without iSof.
    win_log.delete();
    send_frame(0, 1'b1, 1'b0);
    send_frame(100, 1'b0, 1'b0);
    idle(3);
    check_frames("s3", 2, 0, 100);
    if (win_log.size() == 12) begin
      chk("s3_f2_fij", win_log[6].win[39:32], 8'd117);
      chk("s3_f2_a", win_log[6].win[71:64], 8'd100);
    end

    // Scenario 4: reset after 8 pixels, then restart with iSof.
    win_log.delete();
    for (int i = 0; i < 8; i++) pixel(i == 0, 1'b1, 8'(60 + i));
    iRst = 1'b1;
    idle(3);
    iRst = 1'b0;
    idle(1);
    send_frame(0, 1'b1, 1'b0);
    idle(3);
    check_frames("s4", 1, 0, 0);
    if (win_log.size() == 6) begin
      first = win_log[0].win;
      chk("s4_first_window", first, {8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34});
    end

    // Scenario 5: iSof at frame pixel 12 restarts the raster.
    win_log.delete();
    for (int i = 0; i < 12; i++) pixel(i == 0, 1'b1, 8'(50 + i));
    chk("s5_no_early_valid", win_log.size(), 0);
    send_frame(200, 1'b1, 1'b0);
    idle(3);
    check_frames("s5", 1, 200, 200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
